// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite slave port between NUM_MASTERS masters.
// Defining ARB_HOLD_LIMIT_EN caps how many beats an owner may run while others wait.
module ahb_master_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_GRANT_BEATS = 8,
    localparam int MW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              HCLK,
    input  logic                              HRESETn,
    input  logic [NUM_MASTERS-1:0]            HBUSREQ,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_HADDR,
    input  logic [NUM_MASTERS*2-1:0]          M_HTRANS,
    input  logic [NUM_MASTERS-1:0]            M_HWRITE,
    input  logic [NUM_MASTERS*3-1:0]          M_HBURST,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] M_HWDATA,
    input  logic                              HREADY,
    output logic [NUM_MASTERS-1:0]            HGRANT,
    output logic [MW-1:0]                     HMASTER,
    output logic [ADDR_WIDTH-1:0]             HADDR,
    output logic [1:0]                        HTRANS,
    output logic                              HWRITE,
    output logic [2:0]                        HBURST,
    output logic [DATA_WIDTH-1:0]             HWDATA
);

    // state     | meaning
    // ARB_PARK  | nobody requests; grant parked on last owner
    // ARB_OWN   | owner keeps bus while it requests
    // ARB_BURST | fixed-length burst in flight; grant locked
    typedef enum logic [1:0] {ARB_PARK, ARB_OWN, ARB_BURST} arb_state_e;

    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || MAX_GRANT_BEATS < 1 || MAX_GRANT_BEATS > 255) begin : g_bad_params
        $error("ahb_master_arbiter: parameter out of range");
    end

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          addr_owner_q, addr_owner_d;
    logic [MW-1:0]          data_owner_q, data_owner_d;
    logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [MW-1:0]          grant_idx, rr_winner;
    logic [3:0]             beat_cnt_q, beat_cnt_d;
    logic                   locked;
    logic                   hold_force;

    assign HGRANT  = grant_q;
    assign HMASTER = addr_owner_q;
    assign HADDR   = M_HADDR[int'(addr_owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
    assign HTRANS  = M_HTRANS[int'(addr_owner_q)*2 +: 2];
    assign HWRITE  = M_HWRITE[addr_owner_q];
    assign HBURST  = M_HBURST[int'(addr_owner_q)*3 +: 3];
    assign HWDATA  = M_HWDATA[int'(data_owner_q)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (grant_q[i]) grant_idx = MW'(i);
    end

    // Scan downwards so the nearest requester after rr_ptr is the last one written.
    always_comb begin
        rr_winner = rr_ptr_q;
        for (int k = NUM_MASTERS; k >= 1; k--)
            if (HBUSREQ[(int'(rr_ptr_q) + k) % NUM_MASTERS])
                rr_winner = MW'((int'(rr_ptr_q) + k) % NUM_MASTERS);
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (HREADY) begin
            if (HTRANS == TR_NONSEQ) begin
                case (HBURST)
                    3'd2, 3'd3: beat_cnt_d = 4'd3;
                    3'd4, 3'd5: beat_cnt_d = 4'd7;
                    3'd6, 3'd7: beat_cnt_d = 4'd15;
                    default:    beat_cnt_d = 4'd0;
                endcase
            end else if (HTRANS == TR_SEQ && beat_cnt_q != 4'd0) begin
                beat_cnt_d = beat_cnt_q - 4'd1;
            end
        end
    end

    assign locked = (beat_cnt_d != 4'd0);

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_GRANT_BEATS);
    logic [7:0] hold_cnt_q, hold_cnt_d, hold_cnt_inc;

    assign hold_cnt_inc = (HTRANS[1] && hold_cnt_q != 8'hFF) ? hold_cnt_q + 8'd1 : hold_cnt_q;
    assign hold_force   = (hold_cnt_inc >= HOLD_LIMIT) && ((HBUSREQ & ~grant_q) != '0);
    assign hold_cnt_d   = !HREADY ? hold_cnt_q : (grant_d != grant_q) ? 8'd0 : hold_cnt_inc;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) hold_cnt_q <= 8'd0;
        else          hold_cnt_q <= hold_cnt_d;
    end
`else
    assign hold_force = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        addr_owner_d = addr_owner_q;
        data_owner_d = data_owner_q;
        if (HREADY) begin
            addr_owner_d = grant_idx;
            data_owner_d = addr_owner_q;
            if (locked) begin
                state_d = ARB_BURST;
            end else if (HBUSREQ == '0) begin
                state_d = ARB_PARK;
            end else if (state_q == ARB_PARK || !HBUSREQ[grant_idx] || hold_force) begin
                state_d            = ARB_OWN;
                rr_ptr_d           = rr_winner;
                grant_d            = '0;
                grant_d[rr_winner] = 1'b1;
            end else begin
                state_d = ARB_OWN;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ARB_PARK;
            grant_q      <= NUM_MASTERS'(1);
            addr_owner_q <= '0;
            data_owner_q <= '0;
            rr_ptr_q     <= MW'(NUM_MASTERS - 1);
            beat_cnt_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            addr_owner_q <= addr_owner_d;
            data_owner_q <= data_owner_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: directed handover/burst/stall cases, then random traffic
// against a cycle-level reference of the grant/ownership rules.
`timescale 1ns/1ps
module tb_ahb_master_arbiter;
    localparam int NM   = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;
    localparam int MW   = 2;

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic [NM-1:0]    HBUSREQ;
    logic [NM*AW-1:0] M_HADDR;
    logic [NM*2-1:0]  M_HTRANS;
    logic [NM-1:0]    M_HWRITE;
    logic [NM*3-1:0]  M_HBURST;
    logic [NM*DW-1:0] M_HWDATA;
    logic             HREADY;
    logic [NM-1:0]    HGRANT;
    logic [MW-1:0]    HMASTER;
    logic [AW-1:0]    HADDR;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [2:0]       HBURST;
    logic [DW-1:0]    HWDATA;

    logic [AW-1:0] addr_v  [NM];
    logic [1:0]    trans_v [NM];
    logic [2:0]    burst_v [NM];
    logic [DW-1:0] wdata_v [NM];

    int n_cmp = 0;
    int n_mis = 0;

    // reference state
    int m_grant, m_aown, m_down, m_rr, m_beats, m_hold;
    bit m_parked;

    ahb_master_arbiter #(
        .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_GRANT_BEATS(MAXB)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ),
        .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE),
        .M_HBURST(M_HBURST), .M_HWDATA(M_HWDATA), .HREADY(HREADY),
        .HGRANT(HGRANT), .HMASTER(HMASTER), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HBURST(HBURST), .HWDATA(HWDATA)
    );

    always #5 HCLK = ~HCLK;

    always_comb begin
        M_HADDR  = '0;
        M_HTRANS = '0;
        M_HBURST = '0;
        M_HWDATA = '0;
        for (int i = 0; i < NM; i++) begin
            M_HADDR[i*AW +: AW]  = addr_v[i];
            M_HTRANS[i*2 +: 2]   = trans_v[i];
            M_HBURST[i*3 +: 3]   = burst_v[i];
            M_HWDATA[i*DW +: DW] = wdata_v[i];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int burst_len(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_grant = 0; m_aown = 0; m_down = 0; m_rr = NM - 1;
        m_beats = 0; m_hold = 0; m_parked = 1'b1;
    endtask

    // One accepted bus cycle: ownership shifts down the pipe, then the grant is decided.
    task automatic model_edge();
        int t, nb, hold_inc, old_grant;
        bit force_pick;
        if (!HREADY) return;
        t  = int'(trans_v[m_aown]);
        nb = m_beats;
        if (t == 2)                     nb = burst_len(burst_v[m_aown]) - 1;
        else if (t == 3 && m_beats > 0) nb = m_beats - 1;
        hold_inc   = (t >= 2 && m_hold < 255) ? m_hold + 1 : m_hold;
        force_pick = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        force_pick = (hold_inc >= MAXB) && ((HBUSREQ & ~(NM'(1) << m_grant)) != '0);
`endif
        m_down    = m_aown;
        m_aown    = m_grant;
        m_beats   = nb;
        old_grant = m_grant;
        if (nb != 0) begin
            m_parked = 1'b0;
        end else if (HBUSREQ == '0) begin
            m_parked = 1'b1;
        end else if (m_parked || !HBUSREQ[m_grant] || force_pick) begin
            for (int k = 1; k <= NM; k++) begin
                if (HBUSREQ[(m_rr + k) % NM]) begin
                    m_grant = (m_rr + k) % NM;
                    break;
                end
            end
            m_rr     = m_grant;
            m_parked = 1'b0;
        end
        m_hold = (m_grant != old_grant) ? 0 : hold_inc;
    endtask

    task automatic check_outputs();
        check_val("hgrant",  32'(HGRANT),  32'(1) << m_grant);
        check_val("hmaster", 32'(HMASTER), 32'(m_aown));
        check_val("haddr",   HADDR,        addr_v[m_aown]);
        check_val("htrans",  32'(HTRANS),  32'(trans_v[m_aown]));
        check_val("hwrite",  32'(HWRITE),  32'(M_HWRITE[m_aown]));
        check_val("hburst",  32'(HBURST),  32'(burst_v[m_aown]));
        check_val("hwdata",  HWDATA,       wdata_v[m_down]);
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
        model_edge();
        check_outputs();
    endtask

    task automatic randomize_inputs();
        int r;
        HREADY = ($urandom_range(0, 3) != 0);
        for (int m = 0; m < NM; m++) begin
            if ($urandom_range(0, 3) == 0) HBUSREQ[m] = ~HBUSREQ[m];
            r = $urandom_range(0, 9);
            trans_v[m]  = (r < 2) ? 2'd0 : (r == 2) ? 2'd1 : (r < 6) ? 2'd2 : 2'd3;
            burst_v[m]  = 3'($urandom_range(0, 7));
            addr_v[m]   = $urandom;
            wdata_v[m]  = $urandom;
            M_HWRITE[m] = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        HRESETn  = 1'b0;
        HREADY   = 1'b1;
        HBUSREQ  = '0;
        M_HWRITE = '0;
        for (int m = 0; m < NM; m++) begin
            addr_v[m] = 32'h1000 * (m + 1); trans_v[m] = 2'd0; burst_v[m] = 3'd0;
            wdata_v[m] = 32'hD0D0_0000 + m;
        end
        model_reset();
        repeat (3) @(posedge HCLK);
        #1;
        check_outputs();
        @(negedge HCLK);
        HRESETn = 1'b1;

        // reset state and parking
        #1;
        check_val("rst_grant",   32'(HGRANT),  32'h1);
        check_val("rst_hmaster", 32'(HMASTER), 32'h0);
        check_val("rst_htrans",  32'(HTRANS),  32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("park_grant", 32'(HGRANT), 32'h1);
        end

        // simultaneous requests, then M0 drops
        HBUSREQ = 3'b011;
        step();
        check_val("rr_first", 32'(HGRANT), 32'h1);
        HBUSREQ = 3'b010;
        step();
        check_val("ho_grant",   32'(HGRANT),  32'h2);
        check_val("ho_hm_lag",  32'(HMASTER), 32'h0);
        step();
        check_val("ho_hmaster", 32'(HMASTER), 32'h1);

        // M1 INCR4 write from 0x100 with a 3-cycle stall mid-burst
        HBUSREQ = 3'b011;
        trans_v[1] = 2'd2; burst_v[1] = 3'd3; addr_v[1] = 32'h100; M_HWRITE[1] = 1'b1;
        step();
        check_val("burst_nonseq", 32'(HGRANT), 32'h2);
        HBUSREQ = 3'b001;
        trans_v[1] = 2'd3; addr_v[1] = 32'h104; wdata_v[1] = 32'hCAFE_0100;
        step();
        check_val("burst_b1", 32'(HGRANT), 32'h2);
        addr_v[1] = 32'h108; wdata_v[1] = 32'hCAFE_0104;
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_grant",   32'(HGRANT),  32'h2);
            check_val("stall_hmaster", 32'(HMASTER), 32'h1);
            check_val("stall_hwdata",  HWDATA,       32'hCAFE_0104);
        end
        HREADY = 1'b1;
        step();
        check_val("burst_b2", 32'(HGRANT), 32'h2);
        addr_v[1] = 32'h10C; wdata_v[1] = 32'hCAFE_0108;
        step();
        check_val("burst_release", 32'(HGRANT), 32'h1);
        trans_v[1] = 2'd0;

        // M0 write handed over to M1: write data follows the data-phase owner
        trans_v[0] = 2'd2; burst_v[0] = 3'd0; addr_v[0] = 32'h200; M_HWRITE[0] = 1'b1;
        wdata_v[0] = 32'hA5A5_A5A5;
        step();
        check_val("wr_hmaster0", 32'(HMASTER), 32'h0);
        HBUSREQ = 3'b010;
        step();
        check_val("wr_grant1", 32'(HGRANT), 32'h2);
        trans_v[0] = 2'd0;
        step();
        check_val("wr_hmaster1", 32'(HMASTER), 32'h1);
        check_val("wr_hwdata",   HWDATA,       32'hA5A5_A5A5);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            randomize_inputs();
            step();
        end

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 200 && m_beats == 0; i++) begin
            randomize_inputs();
            step();
        end
        #3;
        HRESETn = 1'b0;
        #1;
        model_reset();
        check_val("async_grant",   32'(HGRANT),  32'h1);
        check_val("async_hmaster", 32'(HMASTER), 32'h0);
        check_outputs();
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            randomize_inputs();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
